// File: rtl/iob_pfsm_in_cond_pkg.sv
// iob_pfsm_in_cond_pkg: mode encodings and output selection for the PFSM input conditioner
package iob_pfsm_in_cond_pkg;
    localparam logic [1:0] MODE_LEVEL = 2'd0;
    localparam logic [1:0] MODE_RISE  = 2'd1;
    localparam logic [1:0] MODE_FALL  = 2'd2;
    localparam logic [1:0] MODE_BOTH  = 2'd3;

    function automatic logic mode_out(input logic [1:0] m, input logic s, input logic sd);
        return m == MODE_LEVEL ? s :
               m == MODE_RISE  ? s & ~sd :
               m == MODE_FALL  ? ~s & sd : s ^ sd;
    endfunction
endpackage

// File: rtl/iob_pfsm_in_bit.sv
// iob_pfsm_in_bit: sync, invert, debounce and level/edge selection for one input bit
module iob_pfsm_in_bit
    import iob_pfsm_in_cond_pkg::*;
#(
    parameter int DBNC_W = 8
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic              in_i,
    input  logic [1:0]        mode_i,
    input  logic              invert_i,
    input  logic [DBNC_W-1:0] dbnc_i,
    output logic              out_o,
    output logic              diff_o
);
    logic r_s1, r_s2, r_stable, r_stable_d;
    logic [DBNC_W-1:0] r_cnt;
    logic w_c, w_stable_nxt, w_out_nxt;
    logic [DBNC_W-1:0] w_cnt_nxt;

    // >= rather than == so a threshold lowered below the running count still fires
    always_comb begin
        w_c          = r_s2 ^ invert_i;
        w_stable_nxt = (w_c != r_stable && r_cnt >= dbnc_i) ? w_c : r_stable;
        w_cnt_nxt    = (w_c == r_stable || r_cnt >= dbnc_i) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
        w_out_nxt    = mode_out(mode_i, r_stable, r_stable_d);
        diff_o       = r_stable ^ r_stable_d;
    end

    iob_reg_r #(.DATA_W(1)) u_s1 (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(in_i), .data_o(r_s1));
    iob_reg_r #(.DATA_W(1)) u_s2 (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(r_s1), .data_o(r_s2));
    iob_reg_r #(.DATA_W(DBNC_W)) u_cnt (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(w_cnt_nxt), .data_o(r_cnt));
    iob_reg_r #(.DATA_W(1)) u_stable (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(w_stable_nxt), .data_o(r_stable));
    iob_reg_r #(.DATA_W(1)) u_stable_d (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(r_stable), .data_o(r_stable_d));
    iob_reg_r #(.DATA_W(1)) u_out (.clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .data_i(w_out_nxt), .data_o(out_o));
endmodule

// File: rtl/iob_reg_r.sv
// iob_reg_r: clock-enabled register with async and sync reset to zero
module iob_reg_r #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) data_o <= '0;
        else if (cke_i) data_o <= rst_i ? '0 : data_i;
endmodule

// File: rtl/iob_pfsm_in_cond.sv
// iob_pfsm_in_cond: per-bit conditioner array feeding the PFSM input_ports bus
module iob_pfsm_in_cond #(
    parameter int INPUT_W = 1,
    parameter int DBNC_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 arst_i,
    input  logic                 rst_i,
    input  logic [INPUT_W-1:0]   in_i,
    input  logic [2*INPUT_W-1:0] mode_i,
    input  logic [INPUT_W-1:0]   invert_i,
    input  logic [DBNC_W-1:0]    dbnc_i,
    output logic [INPUT_W-1:0]   input_ports_o,
    output logic                 changed_o
);
    logic [INPUT_W-1:0] w_diff;

    for (genvar i = 0; i < INPUT_W; i++) begin : g_bit
        iob_pfsm_in_bit #(.DBNC_W(DBNC_W)) u_bit (
            .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i),
            .in_i(in_i[i]), .mode_i(mode_i[2*i+1:2*i]), .invert_i(invert_i[i]),
            .dbnc_i(dbnc_i), .out_o(input_ports_o[i]), .diff_o(w_diff[i])
        );
    end

    iob_reg_r #(.DATA_W(1)) u_changed (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i),
        .data_i(|w_diff), .data_o(changed_o)
    );
endmodule
